array_loader: RTL and testbench

- Write-side counterpart of the CountNoX array reader.
- Accepts a stream of bytes over a valid/ready handshake after `go`, and writes them into an internal 2^AW x SIZE RAM at consecutive addresses from 0.
- Exposes a combinational read port (address in, data out) so CountNox can scan the loaded array in place of the fixed ROM.
- Reports completion on `done`, using the same go/done convention as CountNox.

---
 rtl/array_loader_pkg.sv | 17 +
 rtl/array_loader_if.sv | 30 +++
 rtl/array_loader_ram.sv | 32 +++
 rtl/array_loader.sv | 104 ++++++++++
 tb/tb_array_loader.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/array_loader_pkg.sv
// ----------------------------------------------------------------------------
// array_loader_pkg
// Shared definitions for the array loader: default data/address widths and
// the loader FSM state encoding.
// ----------------------------------------------------------------------------
package array_loader_pkg;

    localparam int SIZE_DEF = 8;   // width of one array entry
    localparam int AW_DEF   = 8;   // address width, depth = 2**AW_DEF

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/array_loader_if.sv
// ----------------------------------------------------------------------------
// array_loader_if
// Bundles the loader's control handshake, the byte stream and the read port.
//   master : initiator side; drives go/len/din/din_valid/rd_addr.
//   slave  : loader side; drives din_ready/rd_data/wr_count/done.
// ----------------------------------------------------------------------------
interface array_loader_if #(
    parameter int SIZE = 8,
    parameter int AW   = 8
);
    logic            go;
    logic [AW:0]     len;
    logic [SIZE-1:0] din;
    logic            din_valid;
    logic            din_ready;
    logic [AW-1:0]   rd_addr;
    logic [SIZE-1:0] rd_data;
    logic [AW:0]     wr_count;
    logic            done;

    modport master (
        output go, len, din, din_valid, rd_addr,
        input  din_ready, rd_data, wr_count, done
    );

    modport slave (
        input  go, len, din, din_valid, rd_addr,
        output din_ready, rd_data, wr_count, done
    );
endinterface

// File: rtl/array_loader_ram.sv
// ----------------------------------------------------------------------------
// array_ram
// 2**AW x SIZE storage with a synchronous write port and an asynchronous
// read port. Contents are deliberately not reset.
//   clk   : write clock
//   we    : write enable, waddr/wdata captured on the rising edge
//   raddr : read address, rdata follows combinationally
// ----------------------------------------------------------------------------
module array_ram #(
    parameter int SIZE = 8,
    parameter int AW   = 8
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [SIZE-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [SIZE-1:0] rdata
);

    logic [SIZE-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // A write to raddr in the same cycle shows up only after the edge.
    assign rdata = mem[raddr];

endmodule

// File: rtl/array_loader.sv
// ----------------------------------------------------------------------------
// array_loader
// After `go`, accepts len bytes over a valid/ready stream and stores them at
// consecutive RAM addresses from 0; `done` follows the go/done convention of
// the CountNox reader, which scans the array through the combinational read
// port.
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : array_loader_if slave (go, len, din stream, read port,
//           wr_count, done)
//
// state | meaning
// IDLE  | waiting for go; len sampled and counters cleared on acceptance
// LOAD  | din_ready high; each valid beat is written and counted
// DONE  | done high; returns to IDLE once go drops
// ----------------------------------------------------------------------------
module array_loader
    import array_loader_pkg::*;
#(
    parameter int SIZE = SIZE_DEF,
    parameter int AW   = AW_DEF
) (
    input logic         clk,
    input logic         reset,
    array_loader_if.slave bus
);

    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]     wr_count_q, wr_count_d;
    logic [AW:0]     len_q, len_d;
    logic            we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            wr_count_q <= '0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_count_q <= wr_count_d;
            len_q      <= len_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        wr_count_d = wr_count_q;
        len_d      = len_q;
        we         = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.go) begin
                    len_d      = bus.len;
                    wr_ptr_d   = '0;
                    wr_count_d = '0;
                    state_d    = (bus.len == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                // go is not looked at here: a started load always runs to len_q.
                if (bus.din_valid) begin
                    we         = 1'b1;
                    wr_ptr_d   = wr_ptr_q + PTR_ONE;
                    wr_count_d = wr_count_q + CNT_ONE;
                    if (wr_count_q == len_q - CNT_ONE) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!bus.go) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Both outputs decode the state register only, so they are glitch-free
    // and independent of din_valid.
    assign bus.din_ready = (state_q == LOAD);
    assign bus.done      = (state_q == DONE);
    assign bus.wr_count  = wr_count_q;

    array_ram #(
        .SIZE (SIZE),
        .AW   (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdata (bus.din),
        .raddr (bus.rd_addr),
        .rdata (bus.rd_data)
    );

endmodule

// File: tb/tb_array_loader.sv
module tb_array_loader;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    // Reference: what the array should hold and which entries are known.
    logic [7:0] mem_m [256];
    bit         mem_v [256];

    array_loader_if #(.SIZE(8), .AW(8)) bus ();

    array_loader #(.SIZE(8), .AW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 random data, 1 data = address, 2 data = 0x11*(index+1), 3 constant 0x5C
    task automatic run_load(input int n, input int gap_pct, input int mode, input bit drop_go);
        int         ptr;
        int         cnt;
        int         budget;
        bit         v;
        logic [7:0] d;
        logic [8:0] n9;
        ptr = 0;
        cnt = 0;
        n9  = n[8:0];
        bus.go        = 1'b1;
        bus.len       = n9;
        bus.din_valid = 1'b0;
        #1;
        check("idle_done", {31'd0, bus.done}, 32'd0);
        check("idle_ready", {31'd0, bus.din_ready}, 32'd0);
        tick();
        if (n == 0) begin
            check("empty_done", {31'd0, bus.done}, 32'd1);
            check("empty_ready", {31'd0, bus.din_ready}, 32'd0);
            check("empty_count", {23'd0, bus.wr_count}, 32'd0);
        end else begin
            budget = n * 20 + 100;
            while (cnt < n && budget > 0) begin
                budget--;
                if (drop_go && cnt == n / 2) bus.go = 1'b0;
                v = ($urandom_range(99) >= gap_pct);
                case (mode)
                    1:       d = ptr[7:0];
                    2:       d = 8'(8'h11 * (cnt + 1));
                    3:       d = 8'h5C;
                    default: d = 8'($urandom_range(255));
                endcase
                bus.din_valid = v;
                bus.din       = d;
                bus.rd_addr   = ptr[7:0];
                #1;
                check("load_done_low", {31'd0, bus.done}, 32'd0);
                check("load_ready", {31'd0, bus.din_ready}, 32'd1);
                check("load_count", {23'd0, bus.wr_count}, cnt);
                if (mem_v[ptr]) check("rd_old_before_edge", {24'd0, bus.rd_data}, {24'd0, mem_m[ptr]});
                tick();
                if (v) begin
                    mem_m[ptr] = d;
                    mem_v[ptr] = 1'b1;
                    if (cnt < n - 1) check("rd_new_after_edge", {24'd0, bus.rd_data}, {24'd0, d});
                    ptr = (ptr + 1) % 256;
                    cnt++;
                end
            end
            bus.din_valid = 1'b0;
            check("load_transfers", cnt, n);
            check("load_done_high", {31'd0, bus.done}, 32'd1);
            check("load_ready_off", {31'd0, bus.din_ready}, 32'd0);
            check("load_final_count", {23'd0, bus.wr_count}, n);
        end
    endtask

    // Finishes a load: while go is held, DONE must ignore din; then go drops.
    task automatic end_load(input int n);
        if (bus.go) begin
            bus.din_valid = 1'b1;
            bus.din       = 8'hEE;
            tick();
            bus.din_valid = 1'b0;
            check("done_hold", {31'd0, bus.done}, 32'd1);
            check("done_hold_count", {23'd0, bus.wr_count}, n);
            bus.go = 1'b0;
        end
        tick();
        check("idle_after_go_drop", {31'd0, bus.done}, 32'd0);
        check("idle_ready_off", {31'd0, bus.din_ready}, 32'd0);
        check("idle_count_held", {23'd0, bus.wr_count}, n);
    endtask

    task automatic readback(input string tag);
        for (int a = 0; a < 256; a++) begin
            if (mem_v[a]) begin
                bus.rd_addr = 8'(a);
                #1;
                check(tag, {24'd0, bus.rd_data}, {24'd0, mem_m[a]});
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < 256; i++) mem_v[i] = 1'b0;

        // Reset held with go and din_valid asserted.
        reset         = 1'b0;
        bus.go        = 1'b1;
        bus.len       = 9'd4;
        bus.din       = 8'h99;
        bus.din_valid = 1'b1;
        bus.rd_addr   = 8'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_done", {31'd0, bus.done}, 32'd0);
            check("rst_ready", {31'd0, bus.din_ready}, 32'd0);
            check("rst_count", {23'd0, bus.wr_count}, 32'd0);
        end
        bus.go        = 1'b0;
        bus.din_valid = 1'b0;
        #2 reset = 1'b1;
        tick();
        check("post_rst_done", {31'd0, bus.done}, 32'd0);
        check("post_rst_ready", {31'd0, bus.din_ready}, 32'd0);

        // Basic back-to-back load of 0x11..0x44.
        run_load(4, 0, 2, 1'b0);
        end_load(4);
        readback("basic_rd");

        // Gappy load.
        run_load(3, 50, 0, 1'b0);
        end_load(3);
        readback("gap_rd");

        // Empty load leaves the array alone.
        run_load(0, 0, 0, 1'b0);
        end_load(0);
        readback("empty_rd");

        // Full-depth load with data = address, go dropped mid-load.
        run_load(256, 30, 1, 1'b1);
        end_load(256);
        readback("full_rd");

        // Random loads.
        for (int k = 0; k < 4; k++) begin
            run_load($urandom_range(1, 40), $urandom_range(0, 60), 0, k[0]);
            end_load(int'(bus.len));
        end
        readback("rand_rd");

        // Reset in the middle of a load.
        bus.go        = 1'b1;
        bus.len       = 9'd8;
        tick();
        bus.din       = 8'hAA;
        bus.din_valid = 1'b1;
        tick();
        mem_m[0] = 8'hAA;
        bus.din  = 8'hBB;
        tick();
        mem_m[1] = 8'hBB;
        check("mid_count", {23'd0, bus.wr_count}, 32'd2);
        bus.din = 8'hCC;
        reset   = 1'b0;
        #1;
        check("midrst_done", {31'd0, bus.done}, 32'd0);
        check("midrst_count", {23'd0, bus.wr_count}, 32'd0);
        check("midrst_ready", {31'd0, bus.din_ready}, 32'd0);
        tick();
        bus.din_valid = 1'b0;
        bus.go        = 1'b0;
        #2 reset = 1'b1;
        tick();
        check("midrst_idle_ready", {31'd0, bus.din_ready}, 32'd0);
        readback("midrst_rd");
        run_load(1, 0, 3, 1'b0);
        end_load(1);
        readback("reload_rd");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
